// File: rtl/alu_pkg.sv
// Shared ALU types and defaults: subtractor FSM states and digit-serial sizing.
package alu_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} sub_state_t;

  localparam int SUB_WIDTH = 32;
  localparam int SUB_DIGIT = 4;

  // Digit counter width; a single-digit datapath still needs one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sub_digit.sv
// Combinational DIGIT-bit ripple adder slice used by the serial subtractor.
module sub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] nb,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign sum[i]  = a[i] ^ nb[i] ^ c[i];
    assign c[i+1]  = (a[i] & nb[i]) | (c[i] & (a[i] ^ nb[i]));
  end

  assign cout = c[DIGIT];

endmodule

// File: rtl/sub_serial.sv
// Digit-serial subtractor: a - b computed as a + ~b + 1, one DIGIT slice per cycle,
// with valid/ready handshakes on both the operand and the result side.
module sub_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH,
  parameter int DIGIT = SUB_DIGIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_w(N);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  sub_state_t state, nxt;

  logic [WIDTH-1:0] a_r, nb_r, diff_r;
  logic [CW-1:0]    cnt;
  logic             carry, borrow_r, ovf_r;
  logic [IW-1:0]    base;
  logic [DIGIT-1:0] dg_a, dg_nb, dg_sum;
  logic             dg_cout;

  // DIGIT is a power of two, so the slice offset is a shift of the counter.
  assign base  = IW'(cnt) << $clog2(DIGIT);
  assign dg_a  = a_r[base +: DIGIT];
  assign dg_nb = nb_r[base +: DIGIT];

  sub_digit #(.DIGIT(DIGIT)) u_dig (
    .a    (dg_a),
    .nb   (dg_nb),
    .cin  (carry),
    .sum  (dg_sum),
    .cout (dg_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt       = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) nxt = CALC;
      end
      CALC: if (cnt == LAST) nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r      <= '0;
      nb_r     <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      diff_r   <= '0;
      borrow_r <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r    <= a;
          nb_r   <= ~b;
          carry  <= 1'b1;
          cnt    <= '0;
          diff_r <= '0;
        end
        CALC: begin
          diff_r[base +: DIGIT] <= dg_sum;
          carry                 <= dg_cout;
          if (cnt == LAST) begin
            // Final slice carries the sign bits; counter parks here until next accept.
            borrow_r <= ~dg_cout;
            ovf_r    <= (a_r[WIDTH-1] ^ ~nb_r[WIDTH-1]) & (dg_sum[DIGIT-1] ^ a_r[WIDTH-1]);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign diff     = diff_r;
  assign borrow   = borrow_r;
  assign overflow = ovf_r;

endmodule

// File: tb/tb_sub_serial.sv
// Self-checking bench for sub_serial at DIGIT = 4, 1 and 32 against a behavioural model.
module tb_sub_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // {diff, borrow, overflow} straight from the arithmetic definition
  function automatic logic [33:0] ref_sub(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] d;
    d = x - y;
    return {d, (x < y), ((x[31] != y[31]) && (d[31] != x[31]))};
  endfunction

  function automatic logic [31:0] rnd();
    case ($urandom_range(5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int DG = (g == 0) ? 4 : (g == 1) ? 1 : 32;
    localparam int NN = 32 / DG;

    logic        rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid, borrow, overflow;
    logic [31:0] a = '0, b = '0, diff;
    int          ops_done = 0;
    bit          done_f = 1'b0;

    bit          m_busy = 1'b0;
    int          m_ready = 0;
    logic [33:0] m_exp = '0, m_last = '0;

    sub_serial #(.WIDTH(32), .DIGIT(DG)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .borrow    (borrow),
      .overflow  (overflow)
    );

    // Model: one op in flight, result appears NN cycles after accept, held until next accept.
    initial begin
      forever begin
        @(negedge clk);
        if (!m_busy) begin
          chk($sformatf("cfg%0d idle handshake", g), {in_ready, out_valid}, 2'b10);
          chk($sformatf("cfg%0d idle result", g), {diff, borrow, overflow}, m_last);
        end else if (cyc < m_ready) begin
          chk($sformatf("cfg%0d calc handshake", g), {in_ready, out_valid}, 2'b00);
        end else begin
          chk($sformatf("cfg%0d done handshake", g), {in_ready, out_valid}, 2'b01);
          chk($sformatf("cfg%0d done result", g), {diff, borrow, overflow}, m_exp);
        end
        if (rst) begin
          m_busy = 1'b0;
          m_last = '0;
        end else if (!m_busy && in_valid) begin
          m_busy  = 1'b1;
          m_ready = cyc + 1 + NN;
          m_exp   = ref_sub(a, b);
        end else if (m_busy && cyc >= m_ready && out_ready) begin
          m_busy = 1'b0;
          m_last = m_exp;
          ops_done++;
        end
      end
    end

    task automatic tick();
      @(posedge clk);
      #1;
    endtask

    task automatic rand_run(input int nops);
      int start, guard;
      start = ops_done;
      guard = 0;
      while (ops_done - start < nops && guard < 60000) begin
        in_valid  = ($urandom_range(3) != 0);
        a         = rnd();
        b         = ($urandom_range(7) == 0) ? a : rnd();
        out_ready = $urandom_range(1);
        tick();
        guard++;
      end
      chk($sformatf("cfg%0d random ops completed", g), 64'(ops_done - start >= nops), 64'd1);
      in_valid  = 1'b0;
      out_ready = 1'b0;
    endtask

    if (g == 0) begin : dir
      task automatic op(input logic [31:0] x, input logic [31:0] y,
                        input logic [33:0] expv, input string nm);
        int w, lat;
        w = 0;
        lat = 0;
        while (!in_ready && w < 100) begin tick(); w++; end
        a = x; b = y; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        while (!out_valid && lat < 100) begin tick(); lat++; end
        chk({nm, " latency"}, 64'(lat), 64'd8);
        chk({nm, " result"}, {diff, borrow, overflow}, expv);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
      endtask

      initial begin
        int lat;
        rst = 1'b1;
        repeat (3) tick();
        chk("reset state", {in_ready, out_valid, diff, borrow, overflow}, {2'b10, 32'd0, 2'b00});
        rst = 1'b0;
        tick();

        op(32'd5,          32'd3,          {32'h0000_0002, 1'b0, 1'b0}, "basic");
        op(32'd0,          32'd1,          {32'hFFFF_FFFF, 1'b1, 1'b0}, "wrap");
        op(32'hDEAD_BEEF,  32'hDEAD_BEEF,  {32'h0000_0000, 1'b0, 1'b0}, "equal");
        op(32'h8000_0000,  32'd1,          {32'h7FFF_FFFF, 1'b0, 1'b1}, "ovf neg-pos");
        op(32'h7FFF_FFFF,  32'hFFFF_FFFF,  {32'h8000_0000, 1'b1, 1'b1}, "ovf pos-neg");

        // Backpressure: result held, second request ignored until release.
        a = 32'd17; b = 32'd10; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin tick(); lat++; end
        chk("bp first result", {diff, borrow, overflow}, {32'd7, 2'b00});
        a = 32'd9; b = 32'd4; in_valid = 1'b1;
        repeat (20) begin
          tick();
          chk("bp hold", {in_ready, out_valid, diff, borrow, overflow}, {2'b01, 32'd7, 2'b00});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp released", {in_ready, out_valid}, 2'b10);
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin tick(); lat++; end
        chk("bp queued pair latency", 64'(lat), 64'd8);
        chk("bp queued pair result", {diff, borrow, overflow}, {32'd5, 2'b00});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset during the third CALC cycle discards the op.
        a = 32'd1234; b = 32'd1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("reset mid-calc", {in_ready, out_valid, diff, borrow, overflow}, {2'b10, 32'd0, 2'b00});
        op(32'd100, 32'd1, {32'd99, 1'b0, 1'b0}, "after reset");

        rand_run(1000);
        done_f = 1'b1;
      end
    end else begin : rnd_only
      initial begin
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        rand_run(1000);
        done_f = 1'b1;
      end
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(cfg[0].done_f && cfg[1].done_f && cfg[2].done_f) && t < 90000) begin
      @(posedge clk);
      t++;
    end
    chk("all configurations finished",
        {61'd0, cfg[2].done_f, cfg[1].done_f, cfg[0].done_f}, 64'd7);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sub_serial.md
# sub_serial

Multi-cycle digit-serial 32-bit subtractor. It is the inverse companion of the combinational ripple adder in the ALU datapath. It accepts an operand pair over a valid/ready handshake and computes `a - b` one DIGIT-bit slice per cycle as `a + ~b + 1`. It returns the difference, unsigned borrow and signed overflow over a second valid/ready handshake. It sits beside the adder in the ALU and serves area-constrained subtract and compare paths.

## Interface
- `WIDTH`, 32: operand/result width. Must be a multiple of `DIGIT`.
- `DIGIT`, 4: bits processed per cycle. Power of two, 1 ≤ DIGIT ≤ WIDTH.
- `clk` input 1: single clock. All state changes on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `in_valid` input 1: operands valid.
- `in_ready` output 1: block can accept operands. High only in IDLE.
- `a` input WIDTH: minuend.
- `b` input WIDTH: subtrahend.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts result.
- `diff` output WIDTH: `a - b` mod 2^WIDTH.
- `borrow` output 1: 1 when a < b as unsigned. Equals ~carry-out of `a + ~b + 1`.
- `overflow` output 1: signed overflow, `(a[MSB] != b[MSB]) && (diff[MSB] != a[MSB])`.

## Operation
- Define N = WIDTH/DIGIT. State machine has states IDLE, CALC and DONE.
- IDLE:
  - `in_ready`=1, `out_valid`=0.
  - On `in_valid && in_ready`: latch `a` and `~b`, set carry=1, set digit counter=0, clear the `diff` accumulator, go to CALC.
- CALC:
  - `in_ready`=0, `out_valid`=0.
  - Each cycle, add digit `cnt` of `a` and `~b` plus carry. Write the DIGIT-bit sum into `diff[cnt*DIGIT +: DIGIT]`. Register the carry-out. Increment `cnt`.
  - On the cycle with cnt == N-1: compute `borrow` = ~final carry and `overflow` from the MSBs, then go to DONE.
- DONE:
  - `out_valid`=1. `diff`, `borrow` and `overflow` are stable and held.
  - On `out_valid && out_ready`: go to IDLE. `diff`, `borrow` and `overflow` keep their values until the next accept.
- Inputs `a`/`b` are sampled only at the accept edge. Changes afterwards have no effect.
- `in_valid` while not in IDLE is ignored. There is no queuing.
- The counter is `$clog2(N)` bits wide (minimum 1) and must not wrap mid-operation.
- Arithmetic is modulo 2^WIDTH. The borrow/overflow rules hold for all operand values, including a == b (diff=0, borrow=0, overflow=0).

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `diff`=0, `borrow`=0, `overflow`=0, counter=0, carry=0.
- `rst` asserted in any state, including mid-CALC or DONE with a pending result, returns to the reset values at the next edge. The in-flight result is discarded.
- Latency: accept at edge E0. Digits are processed at edges E1..EN. `out_valid` is high in the cycle after EN, i.e. N cycles after the accept edge (8 for the defaults).
- Throughput: at most one operation per N+2 cycles. The handshake out of DONE and the handshake into IDLE occur in different cycles, with no bypass.
- `out_ready` held low keeps DONE indefinitely with outputs constant.
- `out_ready` high before `out_valid` has no effect.
- DIGIT == WIDTH: N=1, and the result is valid one cycle after accept.

## Structure
- Package `alu_pkg`:
  - state enum `sub_state_t` {IDLE, CALC, DONE};
  - default width/digit constants.
- Sub-module `sub_digit`: combinational DIGIT-bit adder slice. Inputs: digit a, digit ~b, carry-in. Outputs: sum digit, carry-out. It is a ripple chain internally, matching the existing adder style.
- Top level holds the FSM, operand registers, counter, carry register and result registers.

## Test plan
- Basic: a=5, b=3 → diff=0x00000002, borrow=0, overflow=0, `out_valid` exactly 8 cycles after the accept edge.
- Wrap: a=0, b=1 → diff=0xFFFFFFFF, borrow=1, overflow=0. Also a=b=0xDEADBEEF → diff=0, borrow=0, overflow=0.
- Signed overflow:
  - a=0x80000000, b=1 → diff=0x7FFFFFFF, borrow=0, overflow=1;
  - a=0x7FFFFFFF, b=0xFFFFFFFF → diff=0x80000000, borrow=1, overflow=1.
- Backpressure: hold `out_ready`=0 for 20 cycles after `out_valid` → outputs constant and `in_ready`=0 throughout. A new `in_valid` with a=9, b=4 is ignored until release; after release that pair is accepted and diff=5.
- Reset mid-operation: assert `rst` at the 3rd CALC cycle → next cycle `in_ready`=1, `out_valid`=0, `diff`=0, `borrow`=0, `overflow`=0. A subsequent operation 100-1 gives diff=99.
- Random: 1000 random pairs with random `out_ready` stalls, checked against the reference `a-b`, unsigned compare and signed-overflow models. Repeat with DIGIT=1 and DIGIT=32.
